// File: rtl/jk_seq_pkg.sv
// Shared opcode and FSM state encodings for the JK bank sequencer.
// Optional feature macro used by the slice: JK_SEQ_DOWN_COUNT_EN (opcode 7 = COUNT_DOWN).
package jk_seq_pkg;

    typedef enum logic [2:0] {
        OP_HOLD       = 3'd0,
        OP_LOAD       = 3'd1,
        OP_CLEAR      = 3'd2,
        OP_SET        = 3'd3,
        OP_TOGGLE     = 3'd4,
        OP_COUNT_UP   = 3'd5,
        OP_SHIFT      = 3'd6,
        OP_COUNT_DOWN = 3'd7
    } jk_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } jk_state_e;

endpackage

// File: rtl/jk_drive_decode.sv
// Combinational J/K drive generation from the latched op/data and the bank's Q feedback.
// Opcode 7 is COUNT_DOWN only when JK_SEQ_DOWN_COUNT_EN is defined, otherwise it holds.
module jk_drive_decode
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  jk_op_e           op_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic [WIDTH-1:0] q_fb_i,
    output logic [WIDTH-1:0] j_o,
    output logic [WIDTH-1:0] k_o
);

    logic [WIDTH-1:0] up_s;
    logic [WIDTH-1:0] shift_s;
    logic             up_run_s;
`ifdef JK_SEQ_DOWN_COUNT_EN
    logic [WIDTH-1:0] dn_s;
    logic             dn_run_s;
`endif

    // Toggle enables for counting: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        up_run_s   = 1'b1;
        shift_s[0] = data_i[0];
`ifdef JK_SEQ_DOWN_COUNT_EN
        dn_run_s   = 1'b1;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            up_s[i]  = up_run_s;
            up_run_s = up_run_s & q_fb_i[i];
`ifdef JK_SEQ_DOWN_COUNT_EN
            dn_s[i]  = dn_run_s;
            dn_run_s = dn_run_s & ~q_fb_i[i];
`endif
            if (i > 0) begin
                shift_s[i] = q_fb_i[i-1];
            end else begin
                shift_s[i] = data_i[0];
            end
        end
    end

    // Opcode to J/K mapping.
    always_comb begin
        j_o = {WIDTH{1'b0}};
        k_o = {WIDTH{1'b0}};
        case (op_i)
            OP_HOLD: begin
                j_o = {WIDTH{1'b0}};
                k_o = {WIDTH{1'b0}};
            end
            OP_LOAD: begin
                j_o = data_i;
                k_o = ~data_i;
            end
            OP_CLEAR: begin
                j_o = {WIDTH{1'b0}};
                k_o = {WIDTH{1'b1}};
            end
            OP_SET: begin
                j_o = {WIDTH{1'b1}};
                k_o = {WIDTH{1'b0}};
            end
            OP_TOGGLE: begin
                j_o = {WIDTH{1'b1}};
                k_o = {WIDTH{1'b1}};
            end
            OP_COUNT_UP: begin
                j_o = up_s;
                k_o = up_s;
            end
            OP_SHIFT: begin
                j_o = shift_s;
                k_o = ~shift_s;
            end
            OP_COUNT_DOWN: begin
`ifdef JK_SEQ_DOWN_COUNT_EN
                j_o = dn_s;
                k_o = dn_s;
`else
                j_o = {WIDTH{1'b0}};
                k_o = {WIDTH{1'b0}};
`endif
            end
            default: begin
                j_o = {WIDTH{1'b0}};
                k_o = {WIDTH{1'b0}};
            end
        endcase
    end

endmodule

// File: rtl/jk_bank_sequencer.sv
// Command sequencer driving a bank of JK flops: IDLE -> RUN (N edges) -> DONE -> IDLE.
// Build option: JK_SEQ_DOWN_COUNT_EN enables COUNT_DOWN on opcode 7 (see jk_drive_decode).
module jk_bank_sequencer
    import jk_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic             abort,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             busy,
    output logic             done
);

    jk_state_e        state_q, state_d;
    jk_op_e           op_q, op_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             drive_en_s;
    logic [WIDTH-1:0] j_dec_s, k_dec_s;

    // State, latched command and remaining-edge counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            data_q  <= {WIDTH{1'b0}};
            rem_q   <= {CNT_W{1'b0}};
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
        end
    end

    // Next-state logic; the bank is only driven in RUN cycles without abort.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        data_d     = data_q;
        rem_d      = rem_q;
        drive_en_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d    = jk_op_e'(cmd_op);
                    data_d  = cmd_data;
                    rem_d   = (cmd_count == {CNT_W{1'b0}}) ? CNT_W'(1) : cmd_count;
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    rem_d   = {CNT_W{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    drive_en_s = 1'b1;
                    rem_d      = rem_q - CNT_W'(1);
                    if (rem_q <= CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                rem_d   = {CNT_W{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    jk_drive_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .op_i   (op_q),
        .data_i (data_q),
        .q_fb_i (q_fb),
        .j_o    (j_dec_s),
        .k_o    (k_dec_s)
    );

    // Reset also forces hold so the bank is untouched on the reset edge.
    assign j         = (drive_en_s && !rst) ? j_dec_s : {WIDTH{1'b0}};
    assign k         = (drive_en_s && !rst) ? k_dec_s : {WIDTH{1'b0}};
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign cmd_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench: sequencer driving a 4-bit behavioural JK bank, checked against an arithmetic register model.
module tb_jk_bank_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [3:0] cmd_data;
    logic [7:0] cmd_count;
    logic       abort;
    logic [3:0] q_bank = 4'b0000;
    logic [3:0] j, k;
    logic       busy, done;
    logic [3:0] exp_q = 4'b0000;
    int         n_checks = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    always @(posedge clk) q_bank <= (j & ~q_bank) | (~k & q_bank);

    jk_bank_sequencer #(.WIDTH(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_count (cmd_count),
        .abort     (abort),
        .q_fb      (q_bank),
        .j         (j),
        .k         (k),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        else n_pass++;
    endtask

    // Register-level meaning of each opcode for one bank edge.
    function automatic logic [3:0] next_q(input logic [2:0] op, input logic [3:0] d, input logic [3:0] q);
        case (op)
            3'd0: next_q = q;
            3'd1: next_q = d;
            3'd2: next_q = 4'b0000;
            3'd3: next_q = 4'b1111;
            3'd4: next_q = ~q;
            3'd5: next_q = q + 4'd1;
            3'd6: next_q = {q[2:0], d[0]};
`ifdef JK_SEQ_DOWN_COUNT_EN
            3'd7: next_q = q - 4'd1;
`else
            3'd7: next_q = q;
`endif
            default: next_q = q;
        endcase
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [3:0] d, input logic [7:0] cnt, input int abort_at);
        int n;
        n = (cnt == 8'd0) ? 1 : int'(cnt);
        @(negedge clk);
        chk("ready_idle", 32'(cmd_ready), 32'd1);
        chk("jk_idle", 32'({j, k}), 32'd0);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        cmd_count = cnt;
        abort     = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        abort     = 1'b0;
        cmd_op    = 3'($urandom);
        cmd_data  = 4'($urandom);
        cmd_count = 8'($urandom);
        chk("busy_start", 32'(busy), 32'd1);
        chk("ready_run", 32'(cmd_ready), 32'd0);
        for (int c = 1; c <= n; c++) begin
            if (c == abort_at) begin
                abort = 1'b1;
                #1;
                chk("jk_abort", 32'({j, k}), 32'd0);
                @(posedge clk); #1;
                abort = 1'b0;
                chk("q_abort", 32'(q_bank), 32'(exp_q));
                break;
            end
            @(posedge clk); #1;
            exp_q = next_q(op, d, exp_q);
            chk("q_run", 32'(q_bank), 32'(exp_q));
            if (c < n) chk("busy_run", 32'(busy), 32'd1);
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd0);
        chk("ready_done", 32'(cmd_ready), 32'd0);
        abort = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        abort = 1'b0;
        chk("done_clear", 32'(done), 32'd0);
        chk("ready_back", 32'(cmd_ready), 32'd1);
        chk("q_hold", 32'(q_bank), 32'(exp_q));
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_data = 4'd0; cmd_count = 8'd0; abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_jk", 32'({j, k}), 32'd0);

        run_cmd(3'd1, 4'b1010, 8'd0, 0);
        chk("load_1010", 32'(q_bank), 32'hA);
        run_cmd(3'd1, 4'b1110, 8'd1, 0);
        run_cmd(3'd5, 4'b0000, 8'd3, 0);
        chk("count_wrap", 32'(q_bank), 32'h1);
        run_cmd(3'd2, 4'b0000, 8'd1, 0);
        run_cmd(3'd6, 4'b0001, 8'd4, 0);
        chk("shift_fill", 32'(q_bank), 32'hF);
        run_cmd(3'd2, 4'b0000, 8'd1, 0);
        run_cmd(3'd5, 4'b0000, 8'd200, 3);
        chk("abort_adv2", 32'(q_bank), 32'h2);

        // Reset in the middle of a long TOGGLE.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = 4'd0; cmd_count = 8'd10;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            exp_q = ~exp_q;
            chk("toggle_run", 32'(q_bank), 32'(exp_q));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mrst_jk", 32'({j, k}), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        chk("mrst_ready", 32'(cmd_ready), 32'd1);
        chk("mrst_q", 32'(q_bank), 32'(exp_q));
        @(posedge clk); #1;
        chk("mrst_q2", 32'(q_bank), 32'(exp_q));

        run_cmd(3'd2, 4'b0000, 8'd1, 0);
        run_cmd(3'd7, 4'b0000, 8'd2, 0);
`ifdef JK_SEQ_DOWN_COUNT_EN
        chk("op7_down", 32'(q_bank), 32'hE);
`else
        chk("op7_hold", 32'(q_bank), 32'h0);
`endif

        for (int t = 0; t < 40; t++) begin
            logic [7:0] cnt;
            int n, ab;
            cnt = 8'($urandom_range(0, 6));
            n   = (cnt == 8'd0) ? 1 : int'(cnt);
            ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
            run_cmd(3'($urandom_range(0, 7)), 4'($urandom), cnt, ab);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
